// File: rtl/tick_task_scheduler.sv
// Periodic task scheduler: per-slot tick countdowns raise pending requests, and a
// round-robin arbiter hands out one-hot run grants that are held until the matching done.
module tick_task_scheduler #(
   parameter int N_TASKS  = 4,
   parameter int PERIOD_W = 8,
   localparam int SLOT_W  = (N_TASKS > 1) ? $clog2(N_TASKS) : 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                tick,
   input  logic                cfg_we,
   input  logic [SLOT_W-1:0]   cfg_slot,
   input  logic                cfg_enable,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [N_TASKS-1:0]  done,
   input  logic [N_TASKS-1:0]  overrun_clr,
   output logic [N_TASKS-1:0]  run,
   output logic [N_TASKS-1:0]  pending,
   output logic [N_TASKS-1:0]  overrun,
   output logic                busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [N_TASKS-1:0]    en_q, en_d;
   logic [N_TASKS-1:0]    pending_q, pending_d;
   logic [N_TASKS-1:0]    overrun_q, overrun_d;
   logic [N_TASKS-1:0]    run_q, run_d;
   logic                  busy_q, busy_d;
   logic [SLOT_W-1:0]     last_grant_q, last_grant_d;
   logic [PERIOD_W-1:0]   reload_q [N_TASKS];
   logic [PERIOD_W-1:0]   reload_d [N_TASKS];
   logic [PERIOD_W-1:0]   cnt_q [N_TASKS];
   logic [PERIOD_W-1:0]   cnt_d [N_TASKS];

   logic [N_TASKS-1:0]    fire_s;
   logic [N_TASKS-1:0]    dis_s;
   logic [N_TASKS-1:0]    eligible_s;
   logic [N_TASKS-1:0]    upper_s;
   logic [N_TASKS-1:0]    cand_s;
   logic [N_TASKS-1:0]    grant_vec_s;
   logic [SLOT_W-1:0]     pick_s;

   // Reload holds eff_period-1 so a zero period behaves as one tick.
   always_comb begin
      en_d   = en_q;
      fire_s = {N_TASKS{1'b0}};
      dis_s  = {N_TASKS{1'b0}};
      for (int i = 0; i < N_TASKS; i++) begin
         reload_d[i] = reload_q[i];
         cnt_d[i]    = cnt_q[i];
         if (cfg_we && (cfg_slot == SLOT_W'(i))) begin
            en_d[i]     = cfg_enable;
            reload_d[i] = (cfg_period == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}}
                                                           : cfg_period - PERIOD_W'(1);
            cnt_d[i]    = reload_d[i];
            dis_s[i]    = ~cfg_enable;
         end else if (tick && en_q[i]) begin
            if (cnt_q[i] == {PERIOD_W{1'b0}}) begin
               fire_s[i] = 1'b1;
               cnt_d[i]  = reload_q[i];
            end else begin
               cnt_d[i]  = cnt_q[i] - PERIOD_W'(1);
            end
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
   end

   // Round-robin pick: lowest eligible slot above last_grant, else lowest eligible overall.
   always_comb begin
      eligible_s = pending_q & ~dis_s;
      upper_s    = {N_TASKS{1'b0}};
      for (int i = 0; i < N_TASKS; i++) begin
         upper_s[i] = (SLOT_W'(i) > last_grant_q);
      end
      cand_s = ((eligible_s & upper_s) != {N_TASKS{1'b0}}) ? (eligible_s & upper_s) : eligible_s;
      pick_s = {SLOT_W{1'b0}};
      for (int i = N_TASKS - 1; i >= 0; i--) begin
         pick_s = cand_s[i] ? SLOT_W'(i) : pick_s;
      end
   end

   // Grant handshake plus pending/overrun bookkeeping.
   always_comb begin
      state_d      = state_q;
      run_d        = run_q;
      last_grant_d = last_grant_q;
      grant_vec_s  = {N_TASKS{1'b0}};
      case (state_q)
         IDLE: begin
            if (eligible_s != {N_TASKS{1'b0}}) begin
               grant_vec_s = {{(N_TASKS-1){1'b0}}, 1'b1} << pick_s;
               run_d       = grant_vec_s;
               state_d     = GRANT;
            end else begin
               run_d = {N_TASKS{1'b0}};
            end
         end
         GRANT: begin
            if ((done & run_q) != {N_TASKS{1'b0}}) begin
               for (int i = 0; i < N_TASKS; i++) begin
                  last_grant_d = run_q[i] ? SLOT_W'(i) : last_grant_d;
               end
               run_d   = {N_TASKS{1'b0}};
               state_d = IDLE;
            end else begin
               run_d = run_q;
            end
         end
         default: begin
            run_d   = {N_TASKS{1'b0}};
            state_d = IDLE;
         end
      endcase
      overrun_d = (overrun_q & ~overrun_clr) | (fire_s & pending_q & ~grant_vec_s);
      pending_d = ((pending_q & ~grant_vec_s) | fire_s) & ~dis_s;
      busy_d    = |run_d;
   end

   // All scheduler state and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         en_q         <= {N_TASKS{1'b0}};
         pending_q    <= {N_TASKS{1'b0}};
         overrun_q    <= {N_TASKS{1'b0}};
         run_q        <= {N_TASKS{1'b0}};
         busy_q       <= 1'b0;
         last_grant_q <= SLOT_W'(N_TASKS - 1);
         for (int i = 0; i < N_TASKS; i++) begin
            reload_q[i] <= {PERIOD_W{1'b0}};
            cnt_q[i]    <= {PERIOD_W{1'b0}};
         end
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         run_q        <= run_d;
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
         for (int i = 0; i < N_TASKS; i++) begin
            reload_q[i] <= reload_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   assign run     = run_q;
   assign pending = pending_q;
   assign overrun = overrun_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_tick_task_scheduler.sv
// Scoreboard bench for tick_task_scheduler: a per-slot behavioural model predicts the
// outputs after every edge and the grant order; a monitor process pops and compares.
module tb_tick_task_scheduler;
   localparam int N  = 4;
   localparam int PW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          tick, cfg_we, cfg_enable;
   logic [1:0]    cfg_slot;
   logic [PW-1:0] cfg_period;
   logic [N-1:0]  done, overrun_clr;
   logic [N-1:0]  run, pending, overrun;
   logic          busy;

   always #5 CLK = ~CLK;

   tick_task_scheduler #(.N_TASKS(N), .PERIOD_W(PW)) dut (
      .CLK(CLK), .RST(RST), .tick(tick), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
      .cfg_enable(cfg_enable), .cfg_period(cfg_period), .done(done),
      .overrun_clr(overrun_clr), .run(run), .pending(pending), .overrun(overrun), .busy(busy)
   );

   typedef struct packed {
      logic [N-1:0] run;
      logic [N-1:0] pend;
      logic [N-1:0] ovr;
      logic         busy;
   } exp_t;

   exp_t exp_q[$];
   int   grant_q[$];
   int   seen_q[$];
   int   checks = 0;
   int   errors = 0;
   int   grants_seen = 0;

   // reference model: ticks left until the next fire, counted the plain way
   bit           m_en   [N];
   int           m_per  [N];
   int           m_left [N];
   logic [N-1:0] m_pend, m_ovr;
   int           m_run, m_last;
   int           done_wait, done_lat;
   bit           hold_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_en[i] = 1'b0; m_per[i] = 1; m_left[i] = 0;
      end
      m_pend = '0; m_ovr = '0; m_run = -1; m_last = N - 1; done_wait = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] f, dis, elig;
      int g;
      exp_t e;
      f = '0; dis = '0; g = -1;
      for (int i = 0; i < N; i++) begin
         if (cfg_we && int'(cfg_slot) == i) begin
            m_en[i]   = cfg_enable;
            m_per[i]  = (cfg_period == 0) ? 1 : int'(cfg_period);
            m_left[i] = m_per[i];
            dis[i]    = !cfg_enable;
         end else if (tick && m_en[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
               f[i] = 1'b1;
               m_left[i] = m_per[i];
            end
         end
      end
      elig = m_pend & ~dis;
      if (m_run < 0) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (g < 0 && elig[idx]) g = idx;
         end
         if (g >= 0) begin
            m_run = g;
            m_pend[g] = 1'b0;
            grant_q.push_back(g);
            done_wait = done_lat;
         end
      end else if (done[m_run]) begin
         m_last = m_run;
         m_run  = -1;
      end
      for (int i = 0; i < N; i++) begin
         if (overrun_clr[i]) m_ovr[i] = 1'b0;
         if (f[i]) begin
            if (m_pend[i]) m_ovr[i] = 1'b1;
            m_pend[i] = 1'b1;
         end
         if (dis[i]) m_pend[i] = 1'b0;
      end
      e.run  = (m_run >= 0) ? (N'(1) << m_run) : '0;
      e.pend = m_pend;
      e.ovr  = m_ovr;
      e.busy = (m_run >= 0);
      exp_q.push_back(e);
   endtask

   // task executor: answers the granted slot after done_wait cycles, with noise on other bits
   task automatic drive_done();
      done = N'($urandom);
      if (m_run >= 0) begin
         done[m_run] = 1'b0;
         if (!hold_done) begin
            if (done_wait == 0) done[m_run] = 1'b1;
            else done_wait--;
         end
      end
   endtask

   task automatic cyc(input bit t, input bit we = 1'b0, input int sl = 0, input bit en = 1'b0,
                      input int per = 0, input logic [N-1:0] oc = '0);
      tick = t; cfg_we = we; cfg_slot = sl[1:0]; cfg_enable = en;
      cfg_period = per[PW-1:0]; overrun_clr = oc;
      drive_done();
      model_step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_enable = 1'b0; cfg_period = '0;
      done = '0; overrun_clr = '0;
      #1;
      chk("rst_run", run, 0); chk("rst_pending", pending, 0);
      chk("rst_overrun", overrun, 0); chk("rst_busy", busy, 0);
      exp_q.delete(); grant_q.delete();
      model_reset();
      hold_done = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // monitor: compares every post-edge state and every new grant against the scoreboard
   initial begin
      logic [N-1:0] prev_run;
      exp_t e;
      int gi;
      prev_run = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("run", run, e.run);
            chk("pending", pending, e.pend);
            chk("overrun", overrun, e.ovr);
            chk("busy", busy, e.busy);
            chk("run_onehot0", $onehot0(run), 1);
         end
         if (run !== '0 && prev_run === '0) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (run[i] === 1'b1) gi = i;
            grants_seen++;
            seen_q.push_back(gi);
            if (grant_q.size() > 0) begin
               chk("grant_slot", gi, grant_q.pop_front());
            end else begin
               checks++; errors++;
               $display("FAIL grant_unexpected: got slot %0d expected no grant at %0t", gi, $time);
            end
         end
         prev_run = run;
      end
   end

   initial begin
      int g0;
      int exp_ord[9];
      exp_ord = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
      done_lat = 2;
      do_reset();

      // T1: slot0 period 3, nine ticks, done two cycles after run
      g0 = grants_seen;
      cyc(1'b0, 1'b1, 0, 1'b1, 3);
      for (int t = 0; t < 9; t++) begin cyc(1'b1); idle(5); end
      chk("t1_grants", grants_seen - g0, 3);
      chk("t1_overrun", overrun, 0);

      // T2: three slots period 1, grant order round-robin from slot 0
      do_reset();
      done_lat = 1;
      seen_q.delete();
      for (int s = 0; s < 3; s++) cyc(1'b0, 1'b1, s, 1'b1, 1);
      for (int t = 0; t < 3; t++) begin cyc(1'b1); idle(16); end
      chk("t2_count", seen_q.size(), 9);
      for (int i = 0; i < 9 && i < seen_q.size(); i++) chk("t2_order", seen_q[i], exp_ord[i]);

      // T3: overrun while slot0 is held in GRANT
      do_reset();
      hold_done = 1'b1;
      cyc(1'b0, 1'b1, 0, 1'b1, 1);
      cyc(1'b0, 1'b1, 1, 1'b1, 1);
      cyc(1'b1); idle(2); cyc(1'b1); idle(1);
      chk("t3_overrun", overrun, 4'b0010);
      chk("t3_pending", pending, 4'b0011);
      cyc(1'b0, 1'b0, 0, 1'b0, 0, 4'b0010);
      chk("t3_clr", overrun[1], 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 4'b0010);
      chk("t3_set_wins", overrun[1], 1'b1);
      hold_done = 1'b0;
      idle(20);

      // T4: period 0 fires every tick; config in a tick cycle suppresses the fire
      do_reset();
      done_lat = 1;
      cyc(1'b0, 1'b1, 2, 1'b1, 0);
      for (int t = 0; t < 3; t++) begin cyc(1'b1); idle(6); end
      cyc(1'b1, 1'b1, 2, 1'b1, 0);
      chk("t4_cfg_wins", pending[2], 1'b0);
      cyc(1'b1);
      chk("t4_next_fire", pending[2], 1'b1);
      idle(6);

      // T5: reset in the middle of a grant
      do_reset();
      hold_done = 1'b1;
      cyc(1'b0, 1'b1, 1, 1'b1, 1);
      cyc(1'b1); idle(2); cyc(1'b1); cyc(1'b1); idle(1);
      chk("t5_pre_run", run, 4'b0010);
      do_reset();
      g0 = grants_seen;
      for (int t = 0; t < 4; t++) begin cyc(1'b1); idle(3); end
      chk("t5_no_grant", grants_seen - g0, 0);

      // T6: disable a running slot with a pending rerun
      do_reset();
      hold_done = 1'b1;
      cyc(1'b0, 1'b1, 0, 1'b1, 1);
      cyc(1'b1); idle(2); cyc(1'b1); idle(1);
      chk("t6_pre_pend", pending[0], 1'b1);
      cyc(1'b0, 1'b1, 0, 1'b0, 0);
      chk("t6_pend_clr", pending[0], 1'b0);
      chk("t6_run_held", run[0], 1'b1);
      g0 = grants_seen;
      hold_done = 1'b0;
      idle(6);
      for (int t = 0; t < 3; t++) begin cyc(1'b1); idle(4); end
      chk("t6_no_regrant", grants_seen - g0, 0);
      chk("t6_run_off", run, 0);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         done_lat = $urandom_range(0, 3);
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), $urandom_range(0, N - 1),
             ($urandom_range(0, 3) != 0), $urandom_range(0, 5),
             ($urandom_range(0, 7) == 0) ? N'($urandom) : '0);
      end
      hold_done = 1'b0;
      cyc(1'b0, 1'b1, 0, 1'b0, 0); cyc(1'b0, 1'b1, 1, 1'b0, 0);
      cyc(1'b0, 1'b1, 2, 1'b0, 0); cyc(1'b0, 1'b1, 3, 1'b0, 0);
      idle(12);
      chk("grant_q_empty", grant_q.size(), 0);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
